// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input formatter: widths, ldn range,
// FSM state encoding and the symmetric-rounding helper.
package fft_pkg;

    localparam int MAN_WIDTH = 12;
    localparam int EXP_WIDTH = 6;
    localparam int POS_W     = 11;

    localparam logic [3:0] LDN_MIN = 4'd3;
    localparam logic [3:0] LDN_MAX = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PAD  = 2'd2
    } fsm_state_t;

    // Round a magnitude to nearest after dropping s bits, ties away from zero.
    function automatic logic [31:0] symrnd(input logic [31:0] mag, input int s);
        logic [31:0] half;
        half = (s > 0) ? (32'd1 << (s - 1)) : 32'd0;
        return (mag + half) >> s;
    endfunction

endpackage

// File: rtl/bfp_normalize.sv
// Two-stage block-floating-point normalizer: stage 1 picks the shift from the
// component magnitudes, stage 2 rounds, restores the sign and registers.
module bfp_normalize
    import fft_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int MAN_W = MAN_WIDTH,
    parameter int EXP_W = EXP_WIDTH
) (
    input  logic                    clk_sys,
    input  logic                    rst_sys,
    input  logic                    i_val,
    input  logic signed [IN_W-1:0]  i_re,
    input  logic signed [IN_W-1:0]  i_im,
    output logic                    o_val,
    output logic signed [MAN_W-1:0] o_re,
    output logic signed [MAN_W-1:0] o_im,
    output logic [EXP_W-1:0]        o_exp
);

    localparam int          MAX_S   = IN_W - MAN_W + 1;
    localparam logic [31:0] MAN_MAX = 32'((1 << (MAN_W - 1)) - 1);

    logic [IN_W-1:0]  w_mag_re;
    logic [IN_W-1:0]  w_mag_im;
    logic [EXP_W-1:0] w_shift;
    logic [MAN_W-1:0] w_rnd_re;
    logic [MAN_W-1:0] w_rnd_im;

    logic             r_val1;
    logic [IN_W-1:0]  r_mag_re;
    logic [IN_W-1:0]  r_mag_im;
    logic             r_neg_re;
    logic             r_neg_im;
    logic [EXP_W-1:0] r_shift;

    assign w_mag_re = i_re[IN_W-1] ? (~i_re + 1'b1) : i_re;
    assign w_mag_im = i_im[IN_W-1] ? (~i_im + 1'b1) : i_im;

    // Scan downwards so the last hit is the smallest shift that fits.
    always_comb begin
        w_shift = EXP_W'(MAX_S);
        for (int k = MAX_S; k >= 0; k--) begin
            if (symrnd(32'(w_mag_re), k) <= MAN_MAX &&
                symrnd(32'(w_mag_im), k) <= MAN_MAX)
                w_shift = EXP_W'(k);
        end
    end

    assign w_rnd_re = MAN_W'(symrnd(32'(r_mag_re), int'(r_shift)));
    assign w_rnd_im = MAN_W'(symrnd(32'(r_mag_im), int'(r_shift)));

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            r_val1   <= 1'b0;
            r_mag_re <= '0;
            r_mag_im <= '0;
            r_neg_re <= 1'b0;
            r_neg_im <= 1'b0;
            r_shift  <= '0;
            o_val    <= 1'b0;
            o_re     <= '0;
            o_im     <= '0;
            o_exp    <= '0;
        end else begin
            r_val1   <= i_val;
            r_mag_re <= w_mag_re;
            r_mag_im <= w_mag_im;
            r_neg_re <= i_re[IN_W-1];
            r_neg_im <= i_im[IN_W-1];
            r_shift  <= w_shift;
            o_val    <= r_val1;
            o_re     <= r_neg_re ? (~w_rnd_re + 1'b1) : w_rnd_re;
            o_im     <= r_neg_im ? (~w_rnd_im + 1'b1) : w_rnd_im;
            o_exp    <= r_shift;
        end
    end

endmodule

// File: rtl/fft_in_fmt.sv
// FFT input formatter: frames the input stream to 2^ldn samples (zero-padding
// short frames), normalizes to block-floating-point and generates BF I syncs.
module fft_in_fmt
    import fft_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int MAN_W = MAN_WIDTH,
    parameter int EXP_W = EXP_WIDTH
) (
    input  logic                    clk_sys,
    input  logic                    rst_sys,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sop,
    input  logic                    in_eop,
    input  logic signed [IN_W-1:0]  in_real,
    input  logic signed [IN_W-1:0]  in_imag,
    input  logic [3:0]              ldn_i,
    output logic                    block_sync_o,
    output logic                    stage_sync_o,
    output logic                    data_val_o,
    output logic signed [MAN_W-1:0] data_real_o,
    output logic signed [MAN_W-1:0] data_imag_o,
    output logic [EXP_W-1:0]        data_exp_o,
    output logic [3:0]              ldn_rg_o,
    output logic                    frame_err_o
);

    fsm_state_t       r_state;
    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] r_last;
    logic             r_first_d1;
    logic [3:0]       r_ldn_d1;

    fsm_state_t       w_nxt_state;
    logic [POS_W-1:0] w_nxt_pos;
    logic [POS_W-1:0] w_nxt_last;
    logic             w_beat;
    logic             w_ldn_bad;
    logic [3:0]       w_ldn_eff;
    logic [POS_W-1:0] w_n_last;
    logic             w_slot_val;
    logic             w_slot_first;
    logic             w_slot_zero;
    logic             w_err;
    logic signed [IN_W-1:0] w_slot_re;
    logic signed [IN_W-1:0] w_slot_im;

    assign in_ready  = ~rst_sys & (r_state != ST_PAD);
    assign w_beat    = in_valid & in_ready;
    assign w_ldn_bad = (ldn_i < LDN_MIN) || (ldn_i > LDN_MAX);
    assign w_ldn_eff = w_ldn_bad ? LDN_MAX : ldn_i;
    // N-1 as a mask of ldn ones; wraps correctly for ldn = 11.
    assign w_n_last  = ~({POS_W{1'b1}} << w_ldn_eff);

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_pos    = r_pos;
        w_nxt_last   = r_last;
        w_slot_val   = 1'b0;
        w_slot_first = 1'b0;
        w_slot_zero  = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_beat) begin
                    if (in_sop) begin
                        w_slot_val   = 1'b1;
                        w_slot_first = 1'b1;
                        w_err        = w_ldn_bad;
                        w_nxt_last   = w_n_last;
                        w_nxt_pos    = POS_W'(1);
                        w_nxt_state  = in_eop ? ST_PAD : ST_RUN;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (w_beat) begin
                    w_slot_val = 1'b1;
                    w_err      = in_sop;
                    if (r_pos == r_last) begin
                        w_nxt_pos   = '0;
                        w_nxt_state = ST_IDLE;
                    end else begin
                        w_nxt_pos = r_pos + 1'b1;
                        if (in_eop)
                            w_nxt_state = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                w_slot_val  = 1'b1;
                w_slot_zero = 1'b1;
                if (r_pos == r_last) begin
                    w_nxt_pos   = '0;
                    w_nxt_state = ST_IDLE;
                end else begin
                    w_nxt_pos = r_pos + 1'b1;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    assign w_slot_re = w_slot_zero ? '0 : in_real;
    assign w_slot_im = w_slot_zero ? '0 : in_imag;

    // Sync and ldn travel alongside the normalizer's two stages.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            r_state      <= ST_IDLE;
            r_pos        <= '0;
            r_last       <= '0;
            r_first_d1   <= 1'b0;
            r_ldn_d1     <= '0;
            block_sync_o <= 1'b0;
            ldn_rg_o     <= '0;
            frame_err_o  <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_pos        <= w_nxt_pos;
            r_last       <= w_nxt_last;
            r_first_d1   <= w_slot_first;
            if (w_slot_first)
                r_ldn_d1 <= w_ldn_eff;
            block_sync_o <= r_first_d1;
            if (r_first_d1)
                ldn_rg_o <= r_ldn_d1;
            frame_err_o  <= w_err;
        end
    end

    assign stage_sync_o = block_sync_o;

    bfp_normalize #(
        .IN_W  (IN_W),
        .MAN_W (MAN_W),
        .EXP_W (EXP_W)
    ) u_norm (
        .clk_sys (clk_sys),
        .rst_sys (rst_sys),
        .i_val   (w_slot_val),
        .i_re    (w_slot_re),
        .i_im    (w_slot_im),
        .o_val   (data_val_o),
        .o_re    (data_real_o),
        .o_im    (data_imag_o),
        .o_exp   (data_exp_o)
    );

endmodule

// File: tb/tb_fft_in_fmt.sv
// Self-checking bench for fft_in_fmt: table vectors, framing corner cases and
// randomized traffic against a frame-level reference model.
module tb_fft_in_fmt;

    localparam int IN_W  = 16;
    localparam int MAN_W = 12;
    localparam int EXP_W = 6;

    logic clk_sys = 1'b0;
    logic rst_sys = 1'b1;
    logic in_valid = 1'b0;
    logic in_sop = 1'b0;
    logic in_eop = 1'b0;
    logic signed [IN_W-1:0] in_real = '0;
    logic signed [IN_W-1:0] in_imag = '0;
    logic [3:0] ldn_i = '0;
    logic in_ready, block_sync_o, stage_sync_o, data_val_o, frame_err_o;
    logic signed [MAN_W-1:0] data_real_o, data_imag_o;
    logic [EXP_W-1:0] data_exp_o;
    logic [3:0] ldn_rg_o;

    fft_in_fmt #(.IN_W(IN_W), .MAN_W(MAN_W), .EXP_W(EXP_W)) dut (
        .clk_sys(clk_sys), .rst_sys(rst_sys), .in_valid(in_valid), .in_ready(in_ready),
        .in_sop(in_sop), .in_eop(in_eop), .in_real(in_real), .in_imag(in_imag),
        .ldn_i(ldn_i), .block_sync_o(block_sync_o), .stage_sync_o(stage_sync_o),
        .data_val_o(data_val_o), .data_real_o(data_real_o), .data_imag_o(data_imag_o),
        .data_exp_o(data_exp_o), .ldn_rg_o(ldn_rg_o), .frame_err_o(frame_err_o)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int re; int im; int ex; bit bs; bit ss; int cyc; int ldn;
    } rec_t;

    typedef struct {
        int re; int im; int mr; int mi; int e;
    } vec_t;

    rec_t out_q[$];
    rec_t exp_q[$];
    int   cyc = 0;
    int   err_cnt = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (data_val_o) begin
            rec_t r;
            r.re  = int'(data_real_o);
            r.im  = int'(data_imag_o);
            r.ex  = int'(data_exp_o);
            r.bs  = block_sync_o;
            r.ss  = stage_sync_o;
            r.cyc = cyc;
            r.ldn = int'(ldn_rg_o);
            out_q.push_back(r);
        end
        if (frame_err_o) err_cnt++;
    end

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // Reference: smallest s whose half-away-from-zero rounding of |x|/2^s fits.
    task automatic ref_norm(input int re, input int im, output int mr, output int mi, output int e);
        int ar, ai, rr, ri;
        ar = (re < 0) ? -re : re;
        ai = (im < 0) ? -im : im;
        mr = 0; mi = 0; e = -1;
        for (int s = 0; s <= IN_W - MAN_W + 1; s++) begin
            rr = (2 * ar + (1 << s)) / (1 << (s + 1));
            ri = (2 * ai + (1 << s)) / (1 << (s + 1));
            if (e < 0 && rr <= (1 << (MAN_W - 1)) - 1 && ri <= (1 << (MAN_W - 1)) - 1) begin
                e  = s;
                mr = (re < 0) ? -rr : rr;
                mi = (im < 0) ? -ri : ri;
            end
        end
    endtask

    task automatic push_rec(input int mr, input int mi, input int e, input bit bs, input int ldn, input int pcyc);
        rec_t r;
        r.re = mr; r.im = mi; r.ex = e; r.bs = bs; r.ss = bs; r.cyc = pcyc; r.ldn = ldn;
        exp_q.push_back(r);
    endtask

    task automatic exp_push(input int re, input int im, input bit bs, input int ldn, input int pcyc);
        int mr, mi, e;
        ref_norm(re, im, mr, mi, e);
        push_rec(mr, mi, e, bs, ldn, pcyc);
    endtask

    function automatic int rnd_sample();
        int v;
        v = int'($urandom_range(65535)) - 32768;
        return v >>> $urandom_range(12);
    endfunction

    task automatic beat(input int re, input int im, input bit sop, input bit eop,
                        input int ldn, output int pcyc);
        int guard;
        in_valid = 1'b1;
        in_real  = 16'(re);
        in_imag  = 16'(im);
        in_sop   = sop;
        in_eop   = eop;
        ldn_i    = 4'(ldn);
        guard    = 0;
        while (!in_ready && guard < 4000) begin
            @(posedge clk_sys); #1;
            guard++;
        end
        if (guard >= 4000) chk("ready_wait", int'(in_ready), 1);
        pcyc = cyc;
        @(posedge clk_sys); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        repeat (n) begin
            @(posedge clk_sys); #1;
        end
    endtask

    task automatic collect(input string tag, input int budget);
        int n, k, i;
        rec_t o, e;
        n = exp_q.size();
        k = 0;
        while (out_q.size() < n && k < budget) begin
            @(posedge clk_sys); #1;
            k++;
        end
        repeat (4) @(posedge clk_sys);
        #1;
        chk({tag, "_count"}, out_q.size(), n);
        i = 0;
        while (out_q.size() > 0 && exp_q.size() > 0) begin
            o = out_q.pop_front();
            e = exp_q.pop_front();
            chk($sformatf("%s_re[%0d]", tag, i), o.re, e.re);
            chk($sformatf("%s_im[%0d]", tag, i), o.im, e.im);
            chk($sformatf("%s_exp[%0d]", tag, i), o.ex, e.ex);
            chk($sformatf("%s_bsync[%0d]", tag, i), int'(o.bs), int'(e.bs));
            chk($sformatf("%s_ssync[%0d]", tag, i), int'(o.ss), int'(e.ss));
            if (e.cyc >= 0) chk($sformatf("%s_latency[%0d]", tag, i), o.cyc - e.cyc, 2);
            if (e.bs) chk($sformatf("%s_ldn_rg[%0d]", tag, i), o.ldn, e.ldn);
            i++;
        end
        out_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int p, p_last, re, im, cnt;

        tbl[0] = '{100, -50, 100, -50, 0};
        tbl[1] = '{32767, 0, 1024, 0, 5};
        tbl[2] = '{-2048, 0, -1024, 0, 1};
        tbl[3] = '{-32768, -32768, -1024, -1024, 5};
        tbl[4] = '{2047, -2047, 2047, -2047, 0};
        tbl[5] = '{2048, 3, 1024, 2, 1};
        tbl[6] = '{4095, 1, 1024, 0, 2};
        tbl[7] = '{-3, 5, -3, 5, 0};

        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_data_val", int'(data_val_o), 0);
        chk("rst_ldn_rg", int'(ldn_rg_o), 0);
        chk("rst_bsync", int'(block_sync_o), 0);
        repeat (3) @(posedge clk_sys);
        #1;
        rst_sys = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);
        @(posedge clk_sys); #1;

        // Table frame, ldn = 3
        err_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            beat(tbl[i].re, tbl[i].im, i == 0, i == 7, 3, p);
            push_rec(tbl[i].mr, tbl[i].mi, tbl[i].e, i == 0, 3, p);
        end
        idle(0);
        collect("t1", 50);
        chk("t1_frame_err", err_cnt, 0);

        // Short frame: 5 beats of ldn = 4, then 11 pad slots
        for (int i = 0; i < 5; i++) begin
            re = rnd_sample(); im = rnd_sample();
            beat(re, im, i == 0, i == 4, 4, p);
            exp_push(re, im, i == 0, 4, p);
        end
        idle(0);
        cnt = 0;
        while (!in_ready && cnt < 100) begin
            cnt++;
            @(posedge clk_sys); #1;
        end
        chk("t2_ready_low_cycles", cnt, 11);
        for (int i = 0; i < 11; i++) exp_push(0, 0, 1'b0, 0, -1);
        collect("t2", 50);

        // Two back-to-back ldn = 3 frames
        p_last = 0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) begin
                re = rnd_sample(); im = rnd_sample();
                beat(re, im, i == 0, i == 7, 3, p);
                if (f == 0 && i == 7) p_last = p;
                if (f == 1 && i == 0) chk("t3_b2b_gap", p - p_last, 1);
                exp_push(re, im, i == 0, 3, p);
            end
        end
        idle(0);
        collect("t3", 60);

        // Dropped beat in IDLE, then out-of-range ldn clamped to 11
        err_cnt = 0;
        beat(rnd_sample(), rnd_sample(), 1'b0, 1'b0, 5, p);
        re = rnd_sample(); im = rnd_sample();
        beat(re, im, 1'b1, 1'b1, 13, p);
        exp_push(re, im, 1'b1, 11, p);
        for (int i = 0; i < 2047; i++) exp_push(0, 0, 1'b0, 0, -1);
        idle(0);
        collect("t4", 3000);
        chk("t4_frame_err", err_cnt, 2);

        // Random gaps on ldn = 5, stray sop mid-frame treated as data
        err_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if ($urandom_range(1) == 1) idle(1);
            re = rnd_sample(); im = rnd_sample();
            beat(re, im, (i == 0) || (i == 10), 1'b0, 5, p);
            exp_push(re, im, i == 0, 5, p);
        end
        idle(0);
        collect("t5", 200);
        chk("t5_frame_err", err_cnt, 1);

        // Reset in the middle of an ldn = 4 frame
        for (int i = 0; i < 3; i++) beat(rnd_sample(), rnd_sample(), i == 0, 1'b0, 4, p);
        #2;
        chk("t6_pre_rst_val", int'(data_val_o), 1);
        rst_sys = 1'b1;
        #1;
        chk("t6_rst_val", int'(data_val_o), 0);
        chk("t6_rst_real", int'(data_real_o), 0);
        chk("t6_rst_ldn_rg", int'(ldn_rg_o), 0);
        chk("t6_rst_ready", int'(in_ready), 0);
        idle(0);
        repeat (3) @(posedge clk_sys);
        #1;
        rst_sys = 1'b0;
        out_q.delete();
        exp_q.delete();
        idle(6);
        chk("t6_quiet_after_rst", out_q.size(), 0);
        for (int i = 0; i < 8; i++) begin
            re = rnd_sample(); im = rnd_sample();
            beat(re, im, i == 0, 1'b0, 3, p);
            exp_push(re, im, i == 0, 3, p);
        end
        idle(0);
        collect("t6", 50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
